// File: rtl/wb_port_arbiter_if.sv
// Bundle of the register-file write-port signals shared by the pipeline
// writeback stage, the multi-cycle unit and the decode hazard check.
interface wb_port_arbiter_if;
  logic       wb_we;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       mc_valid;
  logic [2:0] mc_addr;
  logic [7:0] mc_data;
  logic       mc_ready;
  logic [2:0] id_rs1;
  logic [2:0] id_rs2;
  logic       raw_hazard;
  logic       stall_req;
  logic       rf_we;
  logic [2:0] rf_addr;
  logic [7:0] rf_data;

  // Pipeline / multi-cycle unit / decode side
  modport master (
    output wb_we, wb_addr, wb_data,
    output mc_valid, mc_addr, mc_data,
    output id_rs1, id_rs2,
    input  mc_ready, raw_hazard, stall_req,
    input  rf_we, rf_addr, rf_data
  );

  // Arbiter side
  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  mc_valid, mc_addr, mc_data,
    input  id_rs1, id_rs2,
    output mc_ready, raw_hazard, stall_req,
    output rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Pipeline writeback wins by default; a
// multi-cycle result waits in a one-entry buffer and is forced out with a
// one-cycle pipeline stall once it has been blocked STARVE_LIMIT cycles.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            reset,
  wb_port_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Holding buffer and starvation counter
  logic       buf_valid_reg, buf_valid_next;
  logic [2:0] buf_addr_reg,  buf_addr_next;
  logic [7:0] buf_data_reg,  buf_data_next;
  logic [3:0] starve_cnt_reg, starve_cnt_next;

  // Grant decision
  logic       force_drain;
  logic       grant_buf;
  logic       discard_buf;
  logic       handshake;
  logic       grant_we;
  logic [2:0] grant_addr;
  logic [7:0] grant_data;

  // Decode source comparison
  logic [2:0] src_addr [2];
  logic [1:0] src_hit;

  assign src_addr[0] = bus.id_rs1;
  assign src_addr[1] = bus.id_rs2;

  // One comparator per decode source against the buffered destination
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = buf_valid_reg & (src_addr[gi] == buf_addr_reg);
    end
  endgenerate

  // Grant priority: forced drain, then pipeline, then buffer; also next state
  always_comb begin
    force_drain     = 1'b0;
    grant_buf       = 1'b0;
    discard_buf     = 1'b0;
    handshake       = 1'b0;
    grant_we        = 1'b0;
    grant_addr      = 3'd0;
    grant_data      = 8'd0;
    buf_valid_next  = buf_valid_reg;
    buf_addr_next   = buf_addr_reg;
    buf_data_next   = buf_data_reg;
    starve_cnt_next = starve_cnt_reg;

    // While reset is held every input is ignored and the outputs stay low.
    if (reset) begin
      force_drain = buf_valid_reg & (starve_cnt_reg == LIMIT);
      handshake   = bus.mc_valid & ~buf_valid_reg;

      if (force_drain) begin
        grant_buf  = 1'b1;
        grant_we   = 1'b1;
        grant_addr = buf_addr_reg;
        grant_data = buf_data_reg;
      end else if (bus.wb_we) begin
        grant_we   = 1'b1;
        grant_addr = bus.wb_addr;
        grant_data = bus.wb_data;
        // The pipeline value is younger, so a buffered write to the same
        // register would only overwrite it with stale data.
        discard_buf = buf_valid_reg & (buf_addr_reg == bus.wb_addr);
      end else if (buf_valid_reg) begin
        grant_buf  = 1'b1;
        grant_we   = 1'b1;
        grant_addr = buf_addr_reg;
        grant_data = buf_data_reg;
      end

      // Accept only into an empty buffer; a drain never overlaps a load.
      if (handshake) begin
        buf_valid_next = 1'b1;
        buf_addr_next  = bus.mc_addr;
        buf_data_next  = bus.mc_data;
      end else if (grant_buf || discard_buf) begin
        buf_valid_next = 1'b0;
      end

      // Count cycles a full buffer loses the port; reset when it empties.
      if (!buf_valid_next || grant_buf || discard_buf) begin
        starve_cnt_next = 4'd0;
      end else if (buf_valid_reg && (starve_cnt_reg != LIMIT)) begin
        starve_cnt_next = starve_cnt_reg + 4'd1;
      end
    end
  end

  // State registers, cleared as soon as reset asserts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_reg  <= 1'b0;
      buf_addr_reg   <= 3'd0;
      buf_data_reg   <= 8'd0;
      starve_cnt_reg <= 4'd0;
    end else begin
      buf_valid_reg  <= buf_valid_next;
      buf_addr_reg   <= buf_addr_next;
      buf_data_reg   <= buf_data_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign bus.mc_ready   = reset & ~buf_valid_reg;
  assign bus.raw_hazard = |src_hit;
  assign bus.stall_req  = force_drain;
  assign bus.rf_we      = grant_we;
  assign bus.rf_addr    = grant_addr;
  assign bus.rf_data    = grant_data;

endmodule
